// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Holds the multi-cycle result entry layout and the register one-hot helper.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } mc_entry_t;

  // One-hot register mask; r0 maps to an empty mask so it is never tracked.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NREG-1:0] m;
    if (a == {REG_AW{1'b0}}) begin
      m = {NREG{1'b0}};
    end else begin
      m = {{(NREG-1){1'b0}}, 1'b1} << a;
    end
    return m;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular buffer of multi-cycle results awaiting a free regfile write slot.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  mc_entry_t                din,
  output mc_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  mc_entry_t       mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            full_s;
  logic            push_s;
  logic            pop_s;

  assign full_s = (count_r == DEPTH_C);
  assign empty  = (count_r == {(AW+1){1'b0}});
  assign push_s = push && !full_s;
  assign pop_s  = pop && !empty;
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB has priority, multi-cycle results queue and drain on free cycles.
// Optional macro RF_ARB_STARVE_EN adds a starvation counter that forces a one-cycle WB stall.
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [REG_DW-1:0] wb_wdata,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_waddr,
  input  logic [REG_DW-1:0] mc_wdata,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_addr,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [NREG-1:0]   busy,
  output logic              sb_err,
  output logic              wb_stall,
  output logic [3:0]        rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  mc_entry_t       head_s;
  mc_entry_t       din_s;
  logic [CW-1:0]   count_s;
  logic            empty_s;
  logic            wb_own_s;
  logic            push_s;
  logic            pop_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] busy_r;
  logic            sb_err_r;

  assign wb_own_s = (|wb_we) && (wb_waddr != {REG_AW{1'b0}});
  assign mc_ready = (count_s < DEPTH_C);
  assign push_s   = mc_valid && mc_ready;
  assign pop_s    = resetn && !wb_own_s && !empty_s;
  assign din_s    = '{addr: mc_waddr, data: mc_wdata};

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_s),
    .pop    (pop_s),
    .din    (din_s),
    .head   (head_s),
    .count  (count_s),
    .empty  (empty_s)
  );

  // Write-port mux: WB first, then a non-r0 FIFO head, otherwise idle.
  always_comb begin
    rf_we    = 4'h0;
    rf_waddr = head_s.addr;
    rf_wdata = head_s.data;
    if (!resetn) begin
      rf_we = 4'h0;
    end else if (wb_own_s) begin
      rf_we    = wb_we;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (!empty_s && (head_s.addr != {REG_AW{1'b0}})) begin
      rf_we = 4'hF;
    end else begin
      rf_we = 4'h0;
    end
  end

  assign clr_mask_s = pop_s  ? reg_onehot(head_s.addr) : {NREG{1'b0}};
  assign set_mask_s = sb_set ? reg_onehot(sb_addr)     : {NREG{1'b0}};

  // Scoreboard: a same-cycle set overrides the drain clear; re-issuing to a busy register latches an error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_r   <= {NREG{1'b0}};
      sb_err_r <= 1'b0;
    end else begin
      busy_r   <= (busy_r & ~clr_mask_s) | set_mask_s;
      sb_err_r <= sb_err_r | (|(set_mask_s & busy_r & ~clr_mask_s));
    end
  end

  assign busy    = busy_r;
  assign sb_err  = sb_err_r;
  assign hazard1 = busy_r[raddr1] && (raddr1 != {REG_AW{1'b0}});
  assign hazard2 = busy_r[raddr2] && (raddr2 != {REG_AW{1'b0}});

`ifdef RF_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SCW-1:0] STARVE_THR = SCW'(STARVE_LIMIT - 1);

  logic [SCW-1:0] starve_cnt_r;
  logic           stall_s;

  assign stall_s  = !empty_s && (starve_cnt_r >= STARVE_THR);
  assign wb_stall = stall_s;

  // Counts cycles the queued head has been blocked by WB; the stall cycle itself restarts it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (pop_s || stall_s) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (!empty_s && wb_own_s) begin
      starve_cnt_r <= starve_cnt_r + SCW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: queue/set model compared every cycle plus directed literals.
// Builds with or without RF_ARB_STARVE_EN.
module tb_rf_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int SL    = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  wb_we = 4'h0;
  logic [4:0]  wb_waddr = 5'd0;
  logic [31:0] wb_wdata = 32'h0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_waddr = 5'd0;
  logic [31:0] mc_wdata = 32'h0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = 5'd0;
  logic [4:0]  raddr1 = 5'd0;
  logic [4:0]  raddr2 = 5'd0;
  logic        hazard1, hazard2, sb_err, wb_stall;
  logic [31:0] busy;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
    .sb_set(sb_set), .sb_addr(sb_addr), .raddr1(raddr1), .raddr2(raddr2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy), .sb_err(sb_err), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, scoreboard as a bit set.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] busy_m = 32'h0;
  logic        err_m  = 1'b0;
  int          wait_m = 0;
  bit          live   = 1'b0;

  function automatic bit wb_owns();
    return (wb_we != 4'h0) && (wb_waddr != 5'd0);
  endfunction

  function automatic bit exp_stall();
`ifdef RF_ARB_STARVE_EN
    return (q.size() > 0) && (wait_m >= SL - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      busy_m = 32'h0;
      err_m  = 1'b0;
      wait_m = 0;
      live   = 1'b1;
    end else if (live) begin
      bit   own, pop, stall, push;
      ent_t h;
      own   = wb_owns();
      pop   = !own && (q.size() > 0);
      stall = exp_stall();
      push  = mc_valid && (q.size() < DEPTH);
      if (pop || stall) wait_m = 0;
      else if (q.size() > 0 && own) wait_m++;
      if (sb_set && sb_addr != 5'd0 && busy_m[sb_addr] && !(pop && q[0].a == sb_addr))
        err_m = 1'b1;
      if (pop) begin
        h = q.pop_front();
        if (h.a != 5'd0) busy_m[h.a] = 1'b0;
      end
      if (sb_set && sb_addr != 5'd0) busy_m[sb_addr] = 1'b1;
      if (push) q.push_back('{a: mc_waddr, d: mc_wdata});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      logic [3:0] ew;
      if (!resetn) ew = 4'h0;
      else if (wb_owns()) ew = wb_we;
      else if (q.size() > 0 && q[0].a != 5'd0) ew = 4'hF;
      else ew = 4'h0;
      chk("m_rf_we", {28'h0, rf_we}, {28'h0, ew});
      if (resetn && wb_owns()) begin
        chk("m_rf_waddr_wb", {27'h0, rf_waddr}, {27'h0, wb_waddr});
        chk("m_rf_wdata_wb", rf_wdata, wb_wdata);
        chk("m_wb_contract", {31'h0, busy_m[wb_waddr]}, 32'h0);
      end else if (ew != 4'h0) begin
        chk("m_rf_waddr_mc", {27'h0, rf_waddr}, {27'h0, q[0].a});
        chk("m_rf_wdata_mc", rf_wdata, q[0].d);
      end
      chk("m_mc_ready", {31'h0, mc_ready}, {31'h0, (q.size() < DEPTH)});
      chk("m_busy", busy, busy_m);
      chk("m_hazard1", {31'h0, hazard1}, {31'h0, (busy_m[raddr1] && raddr1 != 5'd0)});
      chk("m_hazard2", {31'h0, hazard2}, {31'h0, (busy_m[raddr2] && raddr2 != 5'd0)});
      chk("m_sb_err", {31'h0, sb_err}, {31'h0, err_m});
      chk("m_wb_stall", {31'h0, wb_stall}, {31'h0, exp_stall()});
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    next(); next();
    resetn = 1'b1;
    mid();
    chk("rst_busy", busy, 32'h0);
    chk("rst_mc_ready", {31'h0, mc_ready}, 32'h1);
    chk("rst_sb_err", {31'h0, sb_err}, 32'h0);
    chk("rst_rf_we", {28'h0, rf_we}, 32'h0);

    // Idle WB, one queued result drains the following cycle.
    next(); sb_set = 1'b1; sb_addr = 5'd5;
    next(); sb_set = 1'b0; raddr1 = 5'd5;
    mc_valid = 1'b1; mc_waddr = 5'd5; mc_wdata = 32'hDEADBEEF;
    mid(); chk("t1_hazard1", {31'h0, hazard1}, 32'h1);
    chk("t1_no_bypass", {28'h0, rf_we}, 32'h0);
    next(); mc_valid = 1'b0;
    mid(); chk("t1_we", {28'h0, rf_we}, 32'hF);
    chk("t1_waddr", {27'h0, rf_waddr}, 32'd5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    next();
    mid(); chk("t1_busy_clr", busy, 32'h0);

    // WB writes r3 continuously while r7 and r9 queue up.
    next(); sb_set = 1'b1; sb_addr = 5'd7; wb_we = 4'hF; wb_waddr = 5'd3; wb_wdata = 32'd1;
    next(); sb_addr = 5'd9; mc_valid = 1'b1; mc_waddr = 5'd7; mc_wdata = 32'h77; wb_wdata = 32'd2;
    next(); sb_set = 1'b0; mc_waddr = 5'd9; mc_wdata = 32'h99; wb_wdata = 32'd3;
    mid(); chk("t2_wb_data", rf_wdata, 32'd3);
    next(); mc_valid = 1'b0; wb_wdata = 32'd4;
    mid(); chk("t2_full", {31'h0, mc_ready}, 32'h0);
    chk("t2_wb_addr", {27'h0, rf_waddr}, 32'd3);
    chk("t2_busy", busy, 32'h280);
    next(); wb_we = 4'h0;
    mid(); chk("t2_r7", {27'h0, rf_waddr}, 32'd7);
    chk("t2_r7d", rf_wdata, 32'h77);
    next();
    mid(); chk("t2_r9", {27'h0, rf_waddr}, 32'd9);
    chk("t2_busy_r7clr", busy, 32'h200);
    next();
    mid(); chk("t2_idle", busy, 32'h0);

    // Same-cycle drain and set keeps r4 busy; a second set latches sb_err.
    next(); sb_set = 1'b1; sb_addr = 5'd4; raddr1 = 5'd4;
    next(); sb_set = 1'b0; mc_valid = 1'b1; mc_waddr = 5'd4; mc_wdata = 32'h44;
    mid(); chk("t3_hazard1", {31'h0, hazard1}, 32'h1);
    next(); mc_valid = 1'b0; sb_set = 1'b1;
    mid(); chk("t3_drain_r4", {27'h0, rf_waddr}, 32'd4);
    next();
    mid(); chk("t3_busy4", busy, 32'h10);
    chk("t3_no_err", {31'h0, sb_err}, 32'h0);
    next(); sb_set = 1'b0;
    mid(); chk("t3_err", {31'h0, sb_err}, 32'h1);

    // r0 results occupy the queue but never write; r0 is never a hazard.
    next(); wb_we = 4'hF; wb_waddr = 5'd3; raddr2 = 5'd0;
    mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'h1234;
    next(); mc_wdata = 32'h5678; sb_set = 1'b1; sb_addr = 5'd0;
    next(); mc_valid = 1'b0; sb_set = 1'b0;
    mid(); chk("t4_full", {31'h0, mc_ready}, 32'h0);
    next(); wb_we = 4'h0;
    mid(); chk("t4_r0_we", {28'h0, rf_we}, 32'h0);
    chk("t4_hazard2", {31'h0, hazard2}, 32'h0);
    next();
    mid(); chk("t4_count_dec", {31'h0, mc_ready}, 32'h1);
    next();

    // Reset with two queued entries and busy=0x30.
    next(); sb_set = 1'b1; sb_addr = 5'd5; wb_we = 4'hF; wb_waddr = 5'd3;
    mc_valid = 1'b1; mc_waddr = 5'd4; mc_wdata = 32'hA4;
    next(); sb_set = 1'b0; mc_waddr = 5'd5; mc_wdata = 32'hA5;
    next(); mc_valid = 1'b0;
    mid(); chk("t5_busy_pre", busy, 32'h30);
    chk("t5_full_pre", {31'h0, mc_ready}, 32'h0);
    next(); resetn = 1'b0;
    mid(); chk("t5_we_forced", {28'h0, rf_we}, 32'h0);
    next(); resetn = 1'b1; wb_we = 4'h0;
    mid(); chk("t5_busy", busy, 32'h0);
    chk("t5_ready", {31'h0, mc_ready}, 32'h1);
    chk("t5_we", {28'h0, rf_we}, 32'h0);
    chk("t5_err", {31'h0, sb_err}, 32'h0);

    // Continuous WB with one queued entry.
    next(); wb_we = 4'hF; wb_waddr = 5'd3; wb_wdata = 32'h33;
    mc_valid = 1'b1; mc_waddr = 5'd6; mc_wdata = 32'h66;
`ifdef RF_ARB_STARVE_EN
    for (int k = 1; k <= SL; k++) begin
      next(); mc_valid = 1'b0;
      wb_we = (k == SL) ? 4'h0 : 4'hF;
      mid(); chk("t6_stall", {31'h0, wb_stall}, {31'h0, (k == SL)});
      if (k == SL) chk("t6_drain", {27'h0, rf_waddr}, 32'd6);
    end
    next(); wb_we = 4'hF;
    mid(); chk("t6_stall_once", {31'h0, wb_stall}, 32'h0);
    chk("t6_wb_back", {27'h0, rf_waddr}, 32'd3);
`else
    for (int k = 1; k <= 12; k++) begin
      next(); mc_valid = 1'b0;
      mid(); chk("t6_no_stall", {31'h0, wb_stall}, 32'h0);
    end
    next(); wb_we = 4'h0;
    mid(); chk("t6_late_drain", {27'h0, rf_waddr}, 32'd6);
`endif
    next(); wb_we = 4'h0;
    next();
    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
